buffer_512_to_64: RTL and testbench
===================================

Name: buffer_512_to_64

Overview:
- Width-converting FIFO. Accepts 512-bit words on the write side and delivers them as 64-bit words on the read side.
- Lane 0 (bits 63:0) of each written word is delivered first, lane 7 (bits 511:448) last.
- Sits between a wide 512-bit producer (e.g. a memory/bus read path) and a 64-bit consumer datapath.
- Single clock domain, first-word-fall-through read side.

Parameters:
- DEPTH, 4, number of 512-bit slots stored. Must be a power of two and at least 2.

Ports:
- clk  input  1  system clock; all logic updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low; clears pointers and occupancy.
- clr  input  1  synchronous clear, active-high; empties the buffer.
- data_in  input  512  write data; lane k is bits 64k+63:64k.
- wr_enable  input  1  write request; one 512-bit word per cycle while high.
- data_out  output  64  current head 64-bit lane (first-word-fall-through).
- rd_enable  input  1  read request; pops one 64-bit lane per cycle while high.
- full  output  1  high when all DEPTH slots are occupied.
- empty  output  1  high when no unread lane remains.
- full_n  output  1  always the inverse of full.

Behaviour:
- Storage: DEPTH x 512-bit slots. Write pointer has slot granularity. Read pointer has slot plus 3-bit lane index. Slot count runs 0..DEPTH.
- Reset (rst=0, asynchronous):
  - Pointers, lane index and count go to 0.
  - Outputs: empty=1, full=0, full_n=1, data_out=0.
  - Storage contents are not cleared.
- clr=1 at a clock edge:
  - Same effect as reset, applied synchronously.
  - Overrides any wr_enable or rd_enable in that cycle.
- Write:
  - On a clock edge with wr_enable=1 and full=0, data_in is stored in the slot at the write pointer.
  - Write pointer increments modulo DEPTH; slot count increments.
  - wr_enable while full: the write is dropped with no state change.
- Read:
  - On a clock edge with rd_enable=1 and empty=0, the lane index increments.
  - When lane 7 is consumed, the lane index wraps to 0, the slot pointer increments modulo DEPTH and the slot count decrements.
  - rd_enable while empty: ignored.
- data_out:
  - Combinational from storage: equals lane[lane index] of the slot at the read pointer whenever empty=0.
  - Equals 0 when empty=1.
  - A written word is visible on data_out the cycle after the write edge, so zero-latency pops are possible.
- Flags:
  - full = (count == DEPTH).
  - empty = (count == 0).
  - Both are registered-state derived: no combinational path from wr_enable/rd_enable to the flags.
- Simultaneous write and read in one cycle are both honoured, each gated by the pre-edge flags.
  - If the read consumes lane 7 and the write is accepted, count is unchanged.
  - A write while full is rejected even if the same-cycle read frees a slot.
  - A read while empty is rejected even if the same-cycle write fills a slot.
- A partially read slot counts as occupied until its lane 7 is popped.
- Wrap-around: pointers wrap at DEPTH with no data corruption across the boundary.

Test Plan:
- Reset: drive rst low mid-cycle, then release. Required: empty=1, full=0, full_n=1, data_out=0; with no enables, flags stay constant.
- Ordering: write {8,7,6,5,4,3,2,1}, {16..9}, {24..17} (lane 0 = 1, 9, 17 respectively), then issue 24 single-cycle reads. Required: data_out sequence 1..24, empty=0 until the 24th pop, then empty=1 and data_out=0.
- Full: write 4 words. Required: full=1 and full_n=0. A 5th write is dropped. 8 reads then deassert full, and a new write succeeds. The remaining 32 reads return data in order, with the 5th-attempt data absent.
- Simultaneous: with 1 slot at lane 7, assert wr_enable and rd_enable together. Required: last lane popped, new word accepted, count unchanged; with DEPTH slots full, a write in the same cycle is rejected.
- Empty read and clr: rd_enable while empty changes nothing. Mid-stream clr=1 for one cycle gives empty=1 the next cycle and the following write reads back from its lane 0.
- Wrap: write/read 10 words continuously, crossing the pointer wrap twice. Required: all 80 lanes are read back in order.

Source files
------------

// File: rtl/buffer_512_to_64.sv
// buffer_512_to_64: width-converting FIFO, 512-bit slots in, 64-bit lanes out.
// Lane 0 of each slot is delivered first; the read side is first-word-fall-through.
module buffer_512_to_64 #(
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic [511:0] data_in,
    input  logic         wr_enable,
    output logic [63:0]  data_out,
    input  logic         rd_enable,
    output logic         full,
    output logic         empty,
    output logic         full_n
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [511:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [2:0]    lane_q, lane_d;
    logic [AW:0]   count_q, count_d;

    logic          wr_acc;
    logic          rd_acc;
    logic          last_lane;
    logic [511:0]  head_word;
    logic [63:0]   head_lane;

    // Flags come only from registered occupancy, never from the enables.
    assign full   = (count_q == FULL_CNT);
    assign empty  = (count_q == '0);
    assign full_n = ~full;

    // Both accepts are gated by pre-edge flags; clr suppresses both.
    assign wr_acc    = wr_enable & ~full  & ~clr;
    assign rd_acc    = rd_enable & ~empty & ~clr;
    assign last_lane = (lane_q == 3'd7);

    // Next-state for pointers, lane index and slot count.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        lane_d  = lane_q;
        count_d = count_q;
        if (clr) begin
            wptr_d  = '0;
            rptr_d  = '0;
            lane_d  = '0;
            count_d = '0;
        end else begin
            if (wr_acc) begin
                wptr_d = wptr_q + 1'b1;
            end
            if (rd_acc) begin
                lane_d = lane_q + 1'b1;
                if (last_lane) begin
                    rptr_d = rptr_q + 1'b1;
                end
            end
            // A slot is released only when its lane 7 is popped.
            case ({wr_acc, rd_acc & last_lane})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer/occupancy registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            lane_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            lane_q  <= lane_d;
            count_q <= count_d;
        end
    end

    // Slot storage; contents are deliberately left untouched by reset and clr.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wptr_q] <= data_in;
        end
    end

    assign head_word = mem_q[rptr_q];

    // Select the current lane of the head slot.
    always_comb begin
        head_lane = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (lane_q == 3'(i)) begin
                head_lane = head_word[i*64 +: 64];
            end
        end
    end

    assign data_out = empty ? '0 : head_lane;

endmodule

// File: tb/tb_buffer_512_to_64.sv
// tb_buffer_512_to_64: scoreboard bench; the model is a queue of 64-bit lanes.
module tb_buffer_512_to_64;

    localparam int unsigned DEPTH = 4;

    logic         clk;
    logic         rst;
    logic         clr;
    logic [511:0] data_in;
    logic         wr_enable;
    logic [63:0]  data_out;
    logic         rd_enable;
    logic         full;
    logic         empty;
    logic         full_n;

    buffer_512_to_64 #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .data_in   (data_in),
        .wr_enable (wr_enable),
        .data_out  (data_out),
        .rd_enable (rd_enable),
        .full      (full),
        .empty     (empty),
        .full_n    (full_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected lanes in delivery order; occupied slots = ceil(lanes/8).
    logic [63:0] exp_q[$];
    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Monitor: compare outputs against the model, then apply the upcoming edge's
    // inputs (stable since the last posedge) to the model.
    always @(negedge clk) begin
        int unsigned slots;
        logic exp_empty, exp_full, do_rd, do_wr;
        if (!rst) begin
            exp_q.delete();
            chk("rst_empty", 64'(empty), 64'd1);
            chk("rst_full", 64'(full), 64'd0);
            chk("rst_full_n", 64'(full_n), 64'd1);
            chk("rst_data", data_out, 64'd0);
        end else begin
            slots     = (exp_q.size() + 7) / 8;
            exp_empty = (exp_q.size() == 0);
            exp_full  = (slots == DEPTH);
            chk("empty", 64'(empty), 64'(exp_empty));
            chk("full", 64'(full), 64'(exp_full));
            chk("full_n", 64'(full_n), 64'(!exp_full));
            chk("data_out", data_out, exp_empty ? 64'd0 : exp_q[0]);
            if (clr) begin
                exp_q.delete();
            end else begin
                do_rd = rd_enable && !exp_empty;
                do_wr = wr_enable && !exp_full;
                if (do_rd) void'(exp_q.pop_front());
                if (do_wr) for (int k = 0; k < 8; k++) exp_q.push_back(data_in[k*64 +: 64]);
            end
        end
    end

    // One cycle of stimulus: drive, then move to just after the next posedge.
    task automatic cyc(input logic wr, input logic rd, input logic [511:0] d, input logic c);
        wr_enable = wr;
        rd_enable = rd;
        data_in   = d;
        clr       = c;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [511:0] rand_word();
        logic [511:0] w;
        for (int k = 0; k < 16; k++) w[k*32 +: 32] = $urandom;
        return w;
    endfunction

    function automatic logic [511:0] seq_word(input int base);
        logic [511:0] w;
        for (int k = 0; k < 8; k++) w[k*64 +: 64] = 64'(base + k);
        return w;
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic rd_n(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, rand_word(), 1'b0);
    endtask

    initial begin
        int sent;
        rst = 1'b0; clr = 1'b0; wr_enable = 1'b0; rd_enable = 1'b0; data_in = '0;
        @(posedge clk); #1;
        idle(3);
        rst = 1'b1;
        idle(3);

        // Ordering: lanes 1..24
        for (int w = 0; w < 3; w++) cyc(1'b1, 1'b0, seq_word(w*8 + 1), 1'b0);
        rd_n(24);
        idle(2);

        // Full: 4 words, dropped 5th, drain a slot, refill, drain all
        for (int w = 0; w < 4; w++) cyc(1'b1, 1'b0, rand_word(), 1'b0);
        cyc(1'b1, 1'b0, rand_word(), 1'b0);
        rd_n(8);
        cyc(1'b1, 1'b0, rand_word(), 1'b0);
        rd_n(32);
        rd_n(3);

        // Simultaneous: one slot at lane 7, then wr+rd together
        cyc(1'b1, 1'b0, rand_word(), 1'b0);
        rd_n(7);
        cyc(1'b1, 1'b1, rand_word(), 1'b0);
        rd_n(8);
        // Full with head at lane 7: same-cycle write must be rejected
        for (int w = 0; w < 4; w++) cyc(1'b1, 1'b0, rand_word(), 1'b0);
        rd_n(7);
        cyc(1'b1, 1'b1, rand_word(), 1'b0);
        rd_n(26);

        // Empty reads and mid-stream clr
        rd_n(3);
        cyc(1'b1, 1'b0, rand_word(), 1'b0);
        cyc(1'b1, 1'b0, rand_word(), 1'b0);
        rd_n(3);
        cyc(1'b1, 1'b1, rand_word(), 1'b1);
        cyc(1'b1, 1'b0, seq_word(100), 1'b0);
        rd_n(8);

        // Wrap: 10 words streamed continuously
        sent = 0;
        for (int i = 0; i < 90; i++) begin
            if (i % 8 == 0 && sent < 10) begin
                cyc(1'b1, 1'b1, rand_word(), 1'b0);
                sent++;
            end else begin
                cyc(1'b0, 1'b1, rand_word(), 1'b0);
            end
        end

        // Randomized traffic with occasional clr
        for (int i = 0; i < 400; i++)
            cyc(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) != 0), rand_word(),
                1'($urandom_range(0, 60) == 0));

        // Mid-cycle asynchronous reset with data in flight
        cyc(1'b1, 1'b0, rand_word(), 1'b0);
        cyc(1'b1, 1'b0, rand_word(), 1'b0);
        idle(1);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        idle(3);
        cyc(1'b1, 1'b0, seq_word(200), 1'b0);
        rd_n(9);
        idle(2);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
